branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameters: LUT_DEPTH, 16, number of branch-offset table entries; PCW, 9, program counter and offset width.
REQ-002 SHALL have ports (name  direction  width  meaning):
- Clk  in  1  clock; all state changes on posedge only.
- Reset  in  1  reset, synchronous, active-high.
- Start  in  1  testbench program request; its high-to-low release starts execution.
- Instr  in  9  current instruction fetched at ProgCtr.
- ProgCtr  in  PCW  current program counter, used for the trace counter only.
- AluZero  in  1  ALU zero result, current cycle.
- AluNeg  in  1  ALU negative result, current cycle.
- LutWe  in  1  branch-table write enable.
- LutAddr  in  4  branch-table write address.
- LutData  in  PCW  branch-table write data: two's-complement offset.
- Target  out  PCW  relative jump amount to the fetch stage.
- CMP_Flag  out  1  take-jump strobe to the fetch stage.
- Done  out  1  program finished; held until the next Start.
- CycleCnt  out  16  RUN-cycle count of the current program.

Function
REQ-003 SHALL decode Instr[8:6] as the opcode: 3'b101 = CMP; 3'b110 = BR; 3'b111 with Instr[5:0]=6'h3F = HALT; every other encoding is plain (PC+1).
REQ-004 SHALL implement FSM states IDLE, ARMED, RUN and DONE.
REQ-005 SHALL make these FSM transitions:
- IDLE -> ARMED when Start=1.
- ARMED -> RUN when Start=0.
- RUN -> DONE on a HALT instruction.
- DONE -> ARMED when Start=1.
- any state -> ARMED when Start=1, including RUN mid-program.
REQ-006 SHALL drive Target=0 and CMP_Flag=1 in IDLE, ARMED and DONE, so the fetch stage holds the PC (PC+0).
REQ-007 SHALL, in RUN for BR, compute Target=LUT[Instr[3:0]] combinationally in the same cycle.
REQ-008 SHALL, in RUN for BR, set CMP_Flag per Instr[5:4]: 00 = always, 01 = Zf, 10 = !Zf, 11 = Nf.
REQ-009 SHALL, in RUN for non-BR instructions, output CMP_Flag=0 and Target=0.
REQ-010 SHALL, in RUN on the HALT cycle, output CMP_Flag=1 and Target=0, so the PC freezes on the HALT address.
REQ-011 SHALL update the registered flags Zf/Nf from AluZero/AluNeg at the end of any RUN cycle whose opcode is CMP; a BR in the next cycle sees the new values.
REQ-012 SHALL hold Zf/Nf in all other cycles and states.
REQ-013 SHALL write the LUT on posedge when LutWe=1, in any state; a write to entry i is visible to BR reads from the next cycle, and a same-cycle read returns the old value.
REQ-014 SHALL let the fetch stage add Target modulo 2^PCW, so wrap-around is legal; negative offsets are two's complement (9'h1FF = -1).
REQ-015 SHALL assert Done exactly while in DONE (registered), rising the cycle after HALT is decoded.
REQ-016 SHALL clear CycleCnt to 0 on the ARMED->RUN transition.
REQ-017 SHALL increment CycleCnt by 1 each RUN cycle (HALT cycle included), saturating at 16'hFFFF, and hold it in DONE.
REQ-018 SHALL ignore Instr, AluZero and AluNeg outside RUN.

Reset
REQ-019 SHALL apply on Reset=1 at posedge: state=IDLE, Zf=0, Nf=0, CycleCnt=0, Done=0.
REQ-020 SHALL reset all LUT entries to 9'd1, so an unloaded branch behaves as PC+1.
REQ-021 SHALL let Reset override Start, LutWe and every other input in the same cycle.
REQ-022 SHALL, while Reset=1, drive outputs Target=0, CMP_Flag=1 and Done=0.
REQ-023 SHALL treat Reset asserted mid-RUN as a complete return to IDLE; the LUT is also re-initialised.

Verification
REQ-024 SHALL cover LUT load then branch: write LUT[3]=9'h1FE, pulse Start, release, Instr=9'b110_00_0011 -> Target=9'h1FE, CMP_Flag=1.
REQ-025 SHALL cover the CMP-to-BR flag dependency: CMP with AluZero=1, next cycle BR cond 01 -> CMP_Flag=1; repeat with AluZero=0 -> CMP_Flag=0, Target=0.
REQ-026 SHALL cover a plain program of 5 non-branch instructions then HALT: Done=1 the cycle after HALT, CycleCnt=6, CMP_Flag=1 and Target=0 while in DONE.
REQ-027 SHALL cover restart from DONE: Start=1 -> Done=0 next cycle; release -> RUN with CycleCnt=0.
REQ-028 SHALL cover reset mid-RUN after a LUT write: Reset one cycle -> state IDLE, LUT[3]=9'd1, Zf=Nf=0, CMP_Flag=1.
REQ-029 SHALL cover the same-cycle LUT hazard: LutWe to entry 5 while BR reads entry 5 -> old Target value this cycle, new value next cycle.

Source files
------------

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch/compare control: run FSM, condition flags, branch-offset table.
module branch_ctrl #(
    parameter int LUT_DEPTH = 16,
    parameter int PCW       = 9
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic [8:0]     Instr,
    input  logic [PCW-1:0] ProgCtr,
    input  logic           AluZero,
    input  logic           AluNeg,
    input  logic           LutWe,
    input  logic [3:0]     LutAddr,
    input  logic [PCW-1:0] LutData,
    output logic [PCW-1:0] Target,
    output logic           CMP_Flag,
    output logic           Done,
    output logic [15:0]    CycleCnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_CMP  = 3'b101;
    localparam logic [2:0] OP_BR   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t         state_q, state_d;
    logic           zf_q, zf_d;
    logic           nf_q, nf_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [PCW-1:0] lut_q [LUT_DEPTH];
    logic [PCW-1:0] lut_d [LUT_DEPTH];

    logic           is_cmp;
    logic           is_br;
    logic           is_halt;
    logic           br_take;
    logic           unused_pc;

    // The program counter only feeds external tracing; it has no role here.
    assign unused_pc = ^ProgCtr;

    assign is_cmp  = (Instr[8:6] == OP_CMP);
    assign is_br   = (Instr[8:6] == OP_BR);
    assign is_halt = (Instr[8:6] == OP_HALT) && (Instr[5:0] == 6'h3F);

    always_comb begin
        br_take = 1'b0;
        case (Instr[5:4])
            2'b00:   br_take = 1'b1;
            2'b01:   br_take = zf_q;
            2'b10:   br_take = !zf_q;
            default: br_take = nf_q;
        endcase
    end

    // Outside RUN (and during reset) the fetch stage is told to jump by zero, i.e. hold.
    always_comb begin
        Target   = '0;
        CMP_Flag = 1'b1;
        if (!Reset && state_q == RUN) begin
            if (is_br) begin
                CMP_Flag = br_take;
                Target   = br_take ? lut_q[Instr[3:0]] : '0;
            end else if (!is_halt) begin
                CMP_Flag = 1'b0;
            end
        end
    end

    assign Done     = (state_q == DONE) && !Reset;
    assign CycleCnt = cnt_q;

    always_comb begin
        state_d = state_q;
        zf_d    = zf_q;
        nf_d    = nf_q;
        cnt_d   = cnt_q;

        if (state_q == RUN) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            if (is_cmp) begin
                zf_d = AluZero;
                nf_d = AluNeg;
            end
        end

        if (Start) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                ARMED: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
                RUN: begin
                    if (is_halt) state_d = DONE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        lut_d = lut_q;
        if (LutWe) lut_d[LutAddr] = LutData;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
            cnt_q   <= '0;
            // Unloaded entries advance by one so a stray branch acts like a plain instruction.
            for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= PCW'(1);
        end else begin
            state_q <= state_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
            cnt_q   <= cnt_d;
            lut_q   <= lut_d;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl.
module tb_branch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Start, AluZero, AluNeg, LutWe;
    logic [8:0]  Instr, ProgCtr, LutData, Target;
    logic [3:0]  LutAddr;
    logic        CMP_Flag, Done;
    logic [15:0] CycleCnt;

    int checks = 0;
    int errors = 0;

    branch_ctrl #(.LUT_DEPTH(16), .PCW(9)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr), .ProgCtr(ProgCtr),
        .AluZero(AluZero), .AluNeg(AluNeg), .LutWe(LutWe), .LutAddr(LutAddr),
        .LutData(LutData), .Target(Target), .CMP_Flag(CMP_Flag), .Done(Done),
        .CycleCnt(CycleCnt)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [8:0] tgt, input logic flag);
        #1;
        chk({tag, ".target"}, 16'(Target), 16'(tgt));
        chk({tag, ".flag"}, 16'(CMP_Flag), 16'(flag));
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Instr = 9'h000; ProgCtr = 9'h000;
        AluZero = 1'b0; AluNeg = 1'b0; LutWe = 1'b0; LutAddr = 4'd0; LutData = 9'h000;
        tick; tick;
        chk_out("rst_out", 9'h000, 1'b1);
        chk("rst_done", 16'(Done), 16'd0);
        chk("rst_cnt", CycleCnt, 16'd0);
        Reset = 1'b0;
        tick;
        chk_out("idle_out", 9'h000, 1'b1);

        // LUT load then branch
        LutWe = 1'b1; LutAddr = 4'd3; LutData = 9'h1FE;
        tick;
        LutWe = 1'b0; Start = 1'b1;
        tick;
        Instr = 9'b110_00_0011;
        chk_out("armed_ignores_instr", 9'h000, 1'b1);
        Start = 1'b0;
        tick;
        chk("run_cnt0", CycleCnt, 16'd0);
        chk_out("br_lut3", 9'h1FE, 1'b1);

        // CMP -> BR flag dependency
        Instr = 9'b101_000000; AluZero = 1'b1;
        chk_out("cmp_plain", 9'h000, 1'b0);
        tick;
        Instr = 9'b110_01_0011; AluZero = 1'b0;
        chk_out("br_zf1", 9'h1FE, 1'b1);
        tick;
        Instr = 9'b101_000000; AluZero = 1'b0;
        tick;
        Instr = 9'b110_01_0011;
        chk_out("br_zf0", 9'h000, 1'b0);
        Instr = 9'b110_10_0011;
        chk_out("br_nzf", 9'h1FE, 1'b1);
        Instr = 9'b110_11_0011;
        chk_out("br_nf0", 9'h000, 1'b0);
        tick;
        Instr = 9'b101_000000; AluNeg = 1'b1; AluZero = 1'b1;
        tick;
        Instr = 9'b110_11_0011; AluNeg = 1'b0;
        chk_out("br_nf1", 9'h1FE, 1'b1);
        tick;

        // Same-cycle LUT write/read hazard on entry 5
        Instr = 9'b110_00_0101; LutWe = 1'b1; LutAddr = 4'd5; LutData = 9'h004;
        chk_out("hazard_old", 9'h001, 1'b1);
        tick;
        LutWe = 1'b0;
        chk_out("hazard_new", 9'h004, 1'b1);

        // Start mid-RUN returns to ARMED
        Start = 1'b1;
        tick;
        chk_out("restart_mid_run", 9'h000, 1'b1);
        Start = 1'b0;
        tick;

        // Plain program of five instructions then HALT
        chk("prog_cnt0", CycleCnt, 16'd0);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: Instr = 9'h000;
                1: Instr = 9'h0AA;
                2: Instr = 9'b111_000000;
                3: Instr = 9'b111_111110;
                default: Instr = 9'b100_111111;
            endcase
            chk_out("plain", 9'h000, 1'b0);
            tick;
        end
        Instr = 9'h1FF;
        chk_out("halt_cycle", 9'h000, 1'b1);
        chk("halt_done_low", 16'(Done), 16'd0);
        tick;
        Instr = 9'b110_00_0011;
        chk("done_high", 16'(Done), 16'd1);
        chk("done_cnt", CycleCnt, 16'd6);
        chk_out("done_out", 9'h000, 1'b1);
        tick;
        chk("done_hold", 16'(Done), 16'd1);
        chk("done_cnt_hold", CycleCnt, 16'd6);

        // Restart from DONE
        Start = 1'b1;
        tick;
        chk("restart_done_low", 16'(Done), 16'd0);
        Start = 1'b0;
        tick;
        chk("restart_cnt0", CycleCnt, 16'd0);
        Instr = 9'h000;
        chk_out("restart_run", 9'h000, 1'b0);
        tick;
        chk("restart_cnt1", CycleCnt, 16'd1);

        // Reset mid-RUN after a LUT write and flag update
        LutWe = 1'b1; LutAddr = 4'd3; LutData = 9'h010;
        tick;
        LutWe = 1'b0; Instr = 9'b101_000000; AluZero = 1'b1; AluNeg = 1'b1;
        tick;
        AluZero = 1'b0; AluNeg = 1'b0;
        Instr = 9'b110_00_0011; Reset = 1'b1; Start = 1'b1;
        chk_out("in_reset_out", 9'h000, 1'b1);
        chk("in_reset_done", 16'(Done), 16'd0);
        tick;
        Reset = 1'b0; Start = 1'b0;
        chk_out("post_reset_idle", 9'h000, 1'b1);
        chk("post_reset_cnt", CycleCnt, 16'd0);
        tick;
        chk_out("reset_beats_start", 9'h000, 1'b1);
        Start = 1'b1;
        tick;
        Start = 1'b0;
        tick;
        Instr = 9'b110_00_0011;
        chk_out("lut3_reinit", 9'h001, 1'b1);
        Instr = 9'b110_01_0011;
        chk_out("zf_cleared", 9'h000, 1'b0);
        Instr = 9'b110_11_0011;
        chk_out("nf_cleared", 9'h000, 1'b0);
        Instr = 9'b110_10_0011;
        chk_out("nzf_after_reset", 9'h001, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
